// File: rtl/tcam_pkg.sv
// -----------------------------------------------------------------------------
// tcam_pkg
// Shared definitions for the 7-bit-key, 64-entry TCAM wrapper and its
// entry-update engine: geometry constants, the writer state encoding and the
// ternary match rule.
// -----------------------------------------------------------------------------
package tcam_pkg;

  localparam int KEY_W   = 7;    // search-key width, also row-address bits per half
  localparam int ENTRIES = 64;   // rule entries, 32 per SRAM half
  localparam int WORD_W  = 32;   // SRAM word width per half
  localparam int ROWS    = 128;  // one row per possible key value

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } tcam_wr_state_e;

  // A key matches a rule when every bit either equals the rule bit or is
  // masked as don't-care.
  function automatic logic tcam_match(
    input logic [KEY_W-1:0] key,
    input logic [KEY_W-1:0] rule_key,
    input logic [KEY_W-1:0] rule_mask
  );
    return &(~(key ^ rule_key) | rule_mask);
  endfunction

endpackage

// File: rtl/tcam7x64_writer.sv
// -----------------------------------------------------------------------------
// tcam7x64_writer
// Entry-update engine for the 7-bit-key, 64-entry TCAM. One accepted request
// rewrites every one of the 128 key rows by read-modify-write so that bit
// `entry` of row k holds "k matches the rule" (or 0 for an invalidate).
//
// Ports
//   clk_i          clock
//   rst_ni         synchronous active-low reset
//   req_valid_i    request valid
//   req_ready_o    engine idle and out of reset, request can be accepted
//   req_entry_i    entry index 0..63 ([5] selects SRAM half)
//   req_key_i      rule key
//   req_mask_i     per-bit don't-care, 1 = X
//   req_install_i  1 = install rule, 0 = invalidate entry
//   busy_o         update in progress
//   done_o         one-cycle completion pulse
//   csb_o/web_o    SRAM chip select / write enable, both active-low
//   wmask_o        SRAM byte write mask
//   addr_o         SRAM address {half, row}
//   wdata_o        SRAM write data
//   rdata_i        SRAM read data, [31:0] lower half, [63:32] upper half
// -----------------------------------------------------------------------------
module tcam7x64_writer #(
  parameter int KEY_W   = 7,
  parameter int ENTRY_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [ENTRY_W-1:0] req_entry_i,
  input  logic [KEY_W-1:0]   req_key_i,
  input  logic [KEY_W-1:0]   req_mask_i,
  input  logic               req_install_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               csb_o,
  output logic               web_o,
  output logic [3:0]         wmask_o,
  output logic [KEY_W:0]     addr_o,
  output logic [31:0]        wdata_o,
  input  logic [63:0]        rdata_i
);

  import tcam_pkg::*;

  tcam_wr_state_e     r_state;
  logic [ENTRY_W-1:0] r_entry;
  logic [KEY_W-1:0]   r_key;
  logic [KEY_W-1:0]   r_mask;
  logic               r_install;
  logic [KEY_W-1:0]   r_k;

  // SRAM-facing outputs are registered; they are computed from the next state
  // so that they line up with the state they belong to.
  logic               r_csb;
  logic               r_web;
  logic [3:0]         r_wmask;
  logic [KEY_W:0]     r_addr;
  logic [WORD_W-1:0]  r_wdata;
  logic               r_busy;
  logic               r_done;

  tcam_wr_state_e     w_state_nxt;
  logic [KEY_W-1:0]   w_k_nxt;
  logic               w_accept;
  logic [WORD_W-1:0]  w_old;
  logic [WORD_W-1:0]  w_word;
  logic               w_m;
  logic               w_csb_nxt;
  logic               w_web_nxt;
  logic [3:0]         w_wmask_nxt;
  logic [KEY_W:0]     w_addr_nxt;
  logic [WORD_W-1:0]  w_wdata_nxt;

  assign req_ready_o = rst_ni & (r_state == ST_IDLE);
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign csb_o       = r_csb;
  assign web_o       = r_web;
  assign wmask_o     = r_wmask;
  assign addr_o      = r_addr;
  assign wdata_o     = r_wdata;

  // Next-state, row counter and next-cycle SRAM command decode.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_accept    = 1'b0;
    w_csb_nxt   = 1'b1;
    w_web_nxt   = 1'b1;
    w_wmask_nxt = 4'b0000;
    w_addr_nxt  = 8'h00;
    w_wdata_nxt = 32'h0000_0000;

    // Row word of the entry's half as returned in CAP, with only this
    // entry's bit replaced. The word is merged straight into the write-data
    // register on the CAP->WR edge, which is where the captured old row lives.
    w_old  = r_entry[5] ? rdata_i[63:32] : rdata_i[31:0];
    w_m    = r_install & tcam_match(r_k, r_key, r_mask);
    w_word = w_old;
    w_word[r_entry[4:0]] = w_m;

    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          w_state_nxt = ST_RD;
          w_k_nxt     = 7'd0;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD:   w_state_nxt = ST_CAP;
      ST_CAP:  w_state_nxt = ST_WR;
      ST_WR: begin
        if (r_k == 7'(ROWS - 1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RD;
          w_k_nxt     = r_k + 7'd1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_RD: begin
        // The wrapper's second port reads the upper half at the same row.
        w_csb_nxt  = 1'b0;
        w_addr_nxt = {1'b0, w_k_nxt};
      end
      ST_WR: begin
        w_csb_nxt   = 1'b0;
        w_web_nxt   = 1'b0;
        w_wmask_nxt = 4'b0001 << r_entry[4:3];
        w_addr_nxt  = {r_entry[5], r_k};
        w_wdata_nxt = w_word;
      end
      default: begin
        w_csb_nxt = 1'b1;
      end
    endcase
  end

  // State, captured request, row counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_entry   <= 6'd0;
      r_key     <= 7'd0;
      r_mask    <= 7'd0;
      r_install <= 1'b0;
      r_k       <= 7'd0;
      r_csb     <= 1'b1;
      r_web     <= 1'b1;
      r_wmask   <= 4'b0000;
      r_addr    <= 8'h00;
      r_wdata   <= 32'h0000_0000;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      if (w_accept) begin
        r_entry   <= req_entry_i;
        r_key     <= req_key_i;
        r_mask    <= req_mask_i;
        r_install <= req_install_i;
      end
      r_csb   <= w_csb_nxt;
      r_web   <= w_web_nxt;
      r_wmask <= w_wmask_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_tcam7x64_writer.sv
// -----------------------------------------------------------------------------
// tb_tcam7x64_writer
// Bench for the TCAM entry-update engine: a behavioural dual-half SRAM, a
// row-by-row ternary-match reference of the expected table contents, and
// timing/handshake checks for each update.
// -----------------------------------------------------------------------------
module tb_tcam7x64_writer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [5:0]  req_entry_i;
  logic [6:0]  req_key_i;
  logic [6:0]  req_mask_i;
  logic        req_install_i;
  logic        busy_o;
  logic        done_o;
  logic        csb_o;
  logic        web_o;
  logic [3:0]  wmask_o;
  logic [7:0]  addr_o;
  logic [31:0] wdata_o;
  logic [63:0] rdata_i = 64'h0;

  logic [31:0] mem_lo [128];
  logic [31:0] mem_hi [128];
  logic [31:0] exp_lo [128];
  logic [31:0] exp_hi [128];

  int          n_vec    = 0;
  int          n_err    = 0;
  int          total_wr = 0;
  int          bad_acc  = 0;
  int          wr_base  = 0;
  logic [5:0]  cur_e    = 6'd0;
  logic        load_req = 1'b0;

  tcam7x64_writer dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_entry_i   (req_entry_i),
    .req_key_i     (req_key_i),
    .req_mask_i    (req_mask_i),
    .req_install_i (req_install_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .csb_o         (csb_o),
    .web_o         (web_o),
    .wmask_o       (wmask_o),
    .addr_o        (addr_o),
    .wdata_o       (wdata_o),
    .rdata_i       (rdata_i)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: registered read of both halves, byte-masked write to the
  // half picked by addr[7]; also audits every access of the running update.
  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < 128; k++) begin
        mem_lo[k] <= exp_lo[k];
        mem_hi[k] <= exp_hi[k];
      end
    end else if (!csb_o) begin
      if (!web_o) begin
        if (wmask_o !== (4'b0001 << cur_e[4:3]) || addr_o[7] !== cur_e[5] ||
            addr_o[6:0] !== 7'(total_wr - wr_base))
          bad_acc <= bad_acc + 1;
        total_wr <= total_wr + 1;
        for (int b = 0; b < 4; b++) begin
          if (wmask_o[b]) begin
            if (addr_o[7]) mem_hi[addr_o[6:0]][8*b +: 8] <= wdata_o[8*b +: 8];
            else           mem_lo[addr_o[6:0]][8*b +: 8] <= wdata_o[8*b +: 8];
          end
        end
      end else begin
        if (addr_o[7] !== 1'b0) bad_acc <= bad_acc + 1;
        rdata_i <= {mem_hi[addr_o[6:0]], mem_lo[addr_o[6:0]]};
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Expected table: a row's entry bit is set when every non-masked key bit
  // agrees with the row number and the rule is being installed.
  function automatic void model_apply(input logic [5:0] e, input logic [6:0] key,
                                      input logic [6:0] mask, input logic inst,
                                      input int first, input int last);
    for (int k = first; k <= last; k++) begin
      logic [6:0] row;
      logic       hit;
      row = 7'(k);
      hit = inst;
      for (int b = 0; b < 7; b++)
        if (!mask[b] && row[b] != key[b]) hit = 1'b0;
      if (e[5]) exp_hi[k][e[4:0]] = hit;
      else      exp_lo[k][e[4:0]] = hit;
    end
  endfunction

  task automatic compare_mem(input string tag, input int skip);
    for (int k = 0; k < 128; k++) begin
      if (k != skip) begin
        check_eq($sformatf("%s_lo%0d", tag, k), {32'h0, mem_lo[k]}, {32'h0, exp_lo[k]});
        check_eq($sformatf("%s_hi%0d", tag, k), {32'h0, mem_hi[k]}, {32'h0, exp_hi[k]});
      end
    end
  endtask

  task automatic preload_mem();
    load_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic issue(input logic [5:0] e, input logic [6:0] key, input logic [6:0] mask,
                       input logic inst);
    req_valid_i   = 1'b1;
    req_entry_i   = e;
    req_key_i     = key;
    req_mask_i    = mask;
    req_install_i = inst;
  endtask

  // Called at a negedge with a request presented; returns after the
  // acceptance edge (end of cycle 0).
  task automatic wait_accept(output int waits);
    waits = 0;
    while (req_ready_o !== 1'b1 && waits < 1000) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 1000) check_eq("accept_timeout", 64'(waits), 64'd0);
    cur_e = req_entry_i;
    @(posedge clk);
    wr_base = total_wr;
  endtask

  // Follows one update through cycles 1..386; optionally keeps valid high
  // with the next request presented.
  task automatic track_op(input string tag, input bit hold, input logic [5:0] ne,
                          input logic [6:0] nk, input logic [6:0] nm, input logic ni);
    int done_at, dn, rd_bad, busy_bad, bad0;
    done_at = -1; dn = 0; rd_bad = 0; busy_bad = 0;
    bad0 = bad_acc;
    for (int c = 1; c <= 386; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (hold) issue(ne, nk, nm, ni);
        else      req_valid_i = 1'b0;
      end
      if (c <= 385) begin
        if (req_ready_o !== 1'b0) rd_bad++;
        if (busy_o !== 1'b1) busy_bad++;
      end
      if (done_o === 1'b1) begin
        dn++;
        if (done_at < 0) done_at = c;
      end
    end
    check_eq({tag, "_done_cycle"}, 64'(done_at), 64'd385);
    check_eq({tag, "_done_pulses"}, 64'(dn), 64'd1);
    check_eq({tag, "_ready_low_cycles_bad"}, 64'(rd_bad), 64'd0);
    check_eq({tag, "_busy_cycles_bad"}, 64'(busy_bad), 64'd0);
    check_eq({tag, "_ready_again"}, {63'd0, req_ready_o}, 64'd1);
    check_eq({tag, "_write_count"}, 64'(total_wr - wr_base), 64'd128);
    check_eq({tag, "_bad_accesses"}, 64'(bad_acc - bad0), 64'd0);
  endtask

  initial begin
    int         w, dn;
    logic [6:0] rk, rm;
    logic [5:0] re;
    logic [31:0] old60, new60;

    rst_ni = 1'b0;
    issue(6'd0, 7'd0, 7'd0, 1'b0);
    req_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_csb", {63'd0, csb_o}, 64'd1);
    check_eq("rst_web", {63'd0, web_o}, 64'd1);
    check_eq("rst_wmask", {60'd0, wmask_o}, 64'd0);
    check_eq("rst_addr", {56'd0, addr_o}, 64'd0);
    check_eq("rst_wdata", {32'd0, wdata_o}, 64'd0);
    check_eq("rst_ready", {63'd0, req_ready_o}, 64'd0);
    check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
    check_eq("rst_done", {63'd0, done_o}, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", {63'd0, req_ready_o}, 64'd1);

    // Install entry 5, key 0x2A, mask 0x01 over an all-ones table.
    for (int k = 0; k < 128; k++) begin exp_lo[k] = 32'hFFFF_FFFF; exp_hi[k] = 32'hFFFF_FFFF; end
    preload_mem();
    issue(6'd5, 7'h2A, 7'h01, 1'b1);
    wait_accept(w);
    model_apply(6'd5, 7'h2A, 7'h01, 1'b1, 0, 127);
    track_op("t1", 1'b0, 6'd0, 7'd0, 7'd0, 1'b0);
    compare_mem("t1", -1);
    check_eq("t1_row2A", {32'd0, mem_lo[42]}, 64'hFFFF_FFFF);
    check_eq("t1_row2B", {32'd0, mem_lo[43]}, 64'hFFFF_FFFF);
    check_eq("t1_row00", {32'd0, mem_lo[0]}, 64'hFFFF_FFDF);

    // Install entry 40 matching every key over an all-zero table.
    for (int k = 0; k < 128; k++) begin exp_lo[k] = 32'h0; exp_hi[k] = 32'h0; end
    preload_mem();
    issue(6'd40, 7'h00, 7'h7F, 1'b1);
    wait_accept(w);
    model_apply(6'd40, 7'h00, 7'h7F, 1'b1, 0, 127);
    track_op("t2", 1'b0, 6'd0, 7'd0, 7'd0, 1'b0);
    compare_mem("t2", -1);
    check_eq("t2_hi77", {32'd0, mem_hi[77]}, 64'h0000_0100);

    // Invalidate entry 40.
    issue(6'd40, 7'h15, 7'h00, 1'b0);
    wait_accept(w);
    model_apply(6'd40, 7'h15, 7'h00, 1'b0, 0, 127);
    track_op("t3", 1'b0, 6'd0, 7'd0, 7'd0, 1'b0);
    compare_mem("t3", -1);
    check_eq("t3_hi5", {32'd0, mem_hi[5]}, 64'h0);

    // Back-to-back: valid held high, second request waits for cycle 386.
    rk = 7'($urandom); rm = 7'($urandom_range(0, 15));
    issue(6'd3, rk, rm, 1'b1);
    wait_accept(w);
    model_apply(6'd3, rk, rm, 1'b1, 0, 127);
    rk = 7'($urandom); rm = 7'($urandom_range(0, 7));
    track_op("t4a", 1'b1, 6'd50, rk, rm, 1'b1);
    wait_accept(w);
    check_eq("t4_second_accept_wait", 64'(w), 64'd0);
    model_apply(6'd50, rk, rm, 1'b1, 0, 127);
    track_op("t4b", 1'b0, 6'd0, 7'd0, 7'd0, 1'b0);
    compare_mem("t4", -1);

    // Reset during the WR of row 60, then a fresh install.
    rk = 7'($urandom); rm = 7'($urandom_range(0, 3));
    issue(6'd12, rk, rm, 1'b1);
    wait_accept(w);
    dn = 0;
    for (int c = 1; c <= 183; c++) begin
      @(negedge clk);
      if (c == 1) req_valid_i = 1'b0;
      if (done_o === 1'b1) dn++;
      if (c == 183) rst_ni = 1'b0;
    end
    @(negedge clk);
    check_eq("t5_rst_csb", {63'd0, csb_o}, 64'd1);
    check_eq("t5_rst_web", {63'd0, web_o}, 64'd1);
    check_eq("t5_rst_ready", {63'd0, req_ready_o}, 64'd0);
    check_eq("t5_rst_busy", {63'd0, busy_o}, 64'd0);
    check_eq("t5_rst_wdata", {32'd0, wdata_o}, 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done_o === 1'b1) dn++;
    end
    check_eq("t5_abort_no_done", 64'(dn), 64'd0);
    old60 = exp_lo[60];
    model_apply(6'd12, rk, rm, 1'b1, 60, 60);
    new60 = exp_lo[60];
    exp_lo[60] = old60;
    model_apply(6'd12, rk, rm, 1'b1, 0, 59);
    compare_mem("t5_abort", 60);
    check_eq("t5_row60_old_or_new", {63'd0, (mem_lo[60] == old60 || mem_lo[60] == new60)}, 64'd1);
    exp_lo[60] = (mem_lo[60] == new60) ? new60 : old60;
    rk = 7'($urandom); rm = 7'($urandom_range(0, 127));
    issue(6'd12, rk, rm, 1'b1);
    wait_accept(w);
    model_apply(6'd12, rk, rm, 1'b1, 0, 127);
    track_op("t5_fresh", 1'b0, 6'd0, 7'd0, 7'd0, 1'b0);
    compare_mem("t5_fresh", -1);

    // Random rules over a random table.
    for (int k = 0; k < 128; k++) begin exp_lo[k] = $urandom; exp_hi[k] = $urandom; end
    preload_mem();
    for (int i = 0; i < 6; i++) begin
      re = 6'($urandom);
      rk = 7'($urandom);
      rm = 7'($urandom) & 7'($urandom);
      issue(re, rk, rm, ($urandom_range(0, 3) != 0));
      wait_accept(w);
      model_apply(re, rk, rm, req_install_i, 0, 127);
      track_op($sformatf("rnd%0d", i), 1'b0, 6'd0, 7'd0, 7'd0, 1'b0);
      compare_mem($sformatf("rnd%0d", i), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tcam7x64_writer.md
# tcam7x64_writer

Entry-update engine for the 7-bit-key, 64-entry TCAM macro wrapper. It accepts one ternary rule per request: entry index, key, don't-care mask and install/invalidate. It then rewrites all 128 key rows of the SRAM by read-modify-write, so that bit `entry` of row `k` equals "k matches rule".

- It is the write-side counterpart of the TCAM search path.
- It drives the wrapper's `csb/web/wmask/addr/wdata` and consumes its 64-bit `rdata`.
- Arbitration against search traffic is external. Search must not be issued while `busy_o=1`.

## Interface
Parameters:
- `KEY_W`, 7, search-key width, equal to the SRAM row-address bits per half. Only the default is supported.
- `ENTRY_W`, 6, entry-index width. Only the default is supported.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset. One clock; reset is synchronous and active-low.
- `req_valid_i`  in  1  request valid
- `req_ready_o`  out  1  engine idle, can accept
- `req_entry_i`  in  6  entry index 0..63
- `req_key_i`  in  7  rule key
- `req_mask_i`  in  7  per-bit don't-care (1 = X)
- `req_install_i`  in  1  1 = install rule, 0 = invalidate entry
- `busy_o`  out  1  update in progress
- `done_o`  out  1  one-cycle pulse on completion
- `csb_o`  out  1  SRAM chip select, active-low
- `web_o`  out  1  SRAM write enable, active-low
- `wmask_o`  out  4  SRAM byte mask
- `addr_o`  out  8  SRAM address
- `wdata_o`  out  32  SRAM write data
- `rdata_i`  in  64  SRAM read data: [31:0] lower half (entries 0-31), [63:32] upper half (entries 32-63)

## Operation
- States: IDLE, RD, CAP, WR, DONE. Registers: req fields, 7-bit row counter `k`, 32-bit `old_q`.
- IDLE: `req_ready_o=1`. On `req_valid_i & req_ready_o`, capture all req fields, set `k=0`, go to RD.
- RD: `csb_o=0`, `web_o=1`, `addr_o={1'b0,k}`. Port 1 of the wrapper reads the upper half at the same `k`. Go to CAP.
- CAP: `csb_o=1`. Capture `old_q` as follows, then go to WR:
  - `e[5]=0`: `old_q = rdata_i[31:0]`.
  - `e[5]=1`: `old_q = rdata_i[63:32]`.
- WR: `csb_o=0`, `web_o=0`, `addr_o={e[5],k}`, `wmask_o = onehot(e[4:3])`.
  - `wdata_o` is `old_q` with bit `e[4:0]` replaced by `m`.
  - `m = install & (&(~(k ^ key) | mask))`.
  - If `k==127`, go to DONE; otherwise increment `k` and go to RD.
- DONE: `done_o=1` for one cycle, then IDLE.
- Only bit `e[4:0]` of each written word may change. All other entries are preserved bit-exactly.
- Invalidate writes 0 to the entry's bit in every row.
- `busy_o=1` in RD/CAP/WR/DONE. `req_ready_o = rst_ni & (state==IDLE)`.
- Requests presented while busy are held off (ready low). No queueing.
- Outside RD/WR: `csb_o=1`, `web_o=1`, `wmask_o=0`, `addr_o=0`, `wdata_o=0`.

## Timing
- SRAM model: inputs sampled at a rising edge; `rdata_i` is valid during the following cycle (CAP).
- Let the acceptance edge end cycle 0:
  - RD/CAP/WR for row `k` occupy cycles `3k+1`, `3k+2`, `3k+3`.
  - The last WR is in cycle 384; `done_o` is high in cycle 385.
  - `req_ready_o` is high again in cycle 386.
- Consecutive rows are distinct addresses, so there is no read-after-write hazard. The RD of row `k+1` immediately follows the WR of row `k`.
- Reset (`rst_ni` low at an edge):
  - State goes to IDLE and `k=0`.
  - `csb_o=1`, `web_o=1`, `wmask_o=0`, `addr_o=0`, `wdata_o=0`, `done_o=0`, `busy_o=0`, `req_ready_o=0` while low.
- Reset mid-update: rows already written keep their new value, the remaining rows are untouched, and no `done_o` is produced. Software must reissue the request.

## Structure
- Shared package `tcam_pkg`:
  - Constants `KEY_W=7`, `ENTRIES=64`, `WORD_W=32`, `ROWS=128`.
  - `tcam_wr_state_e` enum.
  - Function `tcam_match(key, rule_key, rule_mask)`.
- Single module; no sub-module is warranted.

## Test plan
- Reset: hold `rst_ni=0` for 3 cycles → `csb_o=1`, `web_o=1`, `wmask_o=0`, `addr_o=0`, `wdata_o=0`, `req_ready_o=0`, `busy_o=0`, `done_o=0`.
- Preload SRAM model all `0xFFFF_FFFF`; install entry 5, key `0x2A`, mask `0x01`:
  - Rows `0x2A` and `0x2B` stay `0xFFFF_FFFF`.
  - Every other lower row reads `0xFFFF_FFDF`.
  - All writes use `wmask_o=4'b0001`.
  - `done_o` fires 385 cycles after acceptance.
- Preload 0; install entry 40, key `0x00`, mask `0x7F` → all 128 writes hit `addr_o=0x80|k` with `wmask_o=4'b0010`; every upper row = `0x0000_0100`; lower rows untouched.
- After the previous test, invalidate entry 40 → all upper rows = `0x0000_0000`.
- Back-to-back: hold `req_valid_i=1` with two different requests → second accepted only at cycle 386; `req_ready_o=0` throughout the first.
- Reset mid-op during WR of row 60, then a fresh install → no `done_o` for the aborted op; rows 0-59 updated, rows 61-127 untouched; fresh request completes correctly.
